axi4_operand_loader: RTL and testbench

Write-only AXI4 slave that accepts burst writes from the system master into the matrix multiplier's operand buffer. It sits directly downstream of the AXI4 master/interconnect on the S00_AXI port. It converts AW/W/B channel bursts into a single-cycle word write port toward the operand RAM. FIXED, INCR and WRAP bursts of 32-bit beats are supported; malformed requests are drained and answered with SLVERR.

---
 rtl/axi4_operand_loader.sv | 202 ++++++++++++++++++++
 tb/tb_axi4_operand_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_operand_loader.sv
// Write-only AXI4 slave turning AW/W/B bursts into single-cycle operand buffer word writes.
// Optional macro LOADER_WLAST_CHECK_EN enables WLAST-vs-AWLEN consistency checking.
module axi4_operand_loader #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned ID_WIDTH       = 1,
    parameter int unsigned BUF_ADDR_WIDTH = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [ID_WIDTH-1:0]       AWID,
    input  logic [ADDR_WIDTH-1:0]     AWADDR,
    input  logic [7:0]                AWLEN,
    input  logic [2:0]                AWSIZE,
    input  logic [1:0]                AWBURST,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [31:0]               WDATA,
    input  logic [3:0]                WSTRB,
    input  logic                      WLAST,
    input  logic                      WVALID,
    output logic                      WREADY,
    output logic [ID_WIDTH-1:0]       BID,
    output logic [1:0]                BRESP,
    output logic                      BVALID,
    input  logic                      BREADY,
    output logic                      buf_we,
    output logic [BUF_ADDR_WIDTH-1:0] buf_addr,
    output logic [31:0]               buf_wdata,
    output logic [3:0]                buf_wstrb,
    output logic                      busy
);

    typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

    state_e                    state_q, state_d;
    logic [ID_WIDTH-1:0]       id_q, id_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [7:0]                len_q, len_d;
    logic [1:0]                burst_q, burst_d;
    logic [7:0]                cnt_q, cnt_d;
    logic                      err_q, err_d;
    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic [ID_WIDTH-1:0]       bid_q, bid_d;
    logic                      we_q, we_d;
    logic [BUF_ADDR_WIDTH-1:0] baddr_q, baddr_d;
    logic [31:0]               wdata_q, wdata_d;
    logic [3:0]                wstrb_q, wstrb_d;
    logic                      busy_q, busy_d;

    logic                      last_beat;
    logic                      beat_err;
    logic [ADDR_WIDTH-1:0]     wrap_mask;
    logic [ADDR_WIDTH-1:0]     addr_inc;

`ifndef LOADER_WLAST_CHECK_EN
    logic unused_wlast;
    assign unused_wlast = WLAST;
`endif

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        bid_d     = bid_q;
        we_d      = 1'b0;
        baddr_d   = baddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        busy_d    = busy_q;

        last_beat = (cnt_q == len_q);
`ifdef LOADER_WLAST_CHECK_EN
        beat_err  = err_q | (WLAST != last_beat);
`else
        beat_err  = err_q;
`endif
        // Legal WRAP lengths make (AWLEN+1)*4-1 equal to {AWLEN, 2'b11}.
        wrap_mask = ADDR_WIDTH'({len_q, 2'b11});
        addr_inc  = addr_q + ADDR_WIDTH'(4);

        unique case (state_q)
            StIdle: begin
                awready_d = 1'b1;
                wready_d  = 1'b0;
                if (AWVALID && awready_q) begin
                    id_d      = AWID;
                    addr_d    = {AWADDR[ADDR_WIDTH-1:2], 2'b00};
                    len_d     = AWLEN;
                    burst_d   = AWBURST;
                    cnt_d     = '0;
                    err_d     = (AWSIZE != 3'b010) || (AWBURST == 2'b11) ||
                                ((AWBURST == 2'b10) && (AWLEN != 8'd1) && (AWLEN != 8'd3) &&
                                 (AWLEN != 8'd7) && (AWLEN != 8'd15));
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    busy_d    = 1'b1;
                    state_d   = StData;
                end
            end
            StData: begin
                if (WVALID && wready_q) begin
                    we_d    = ~beat_err;
                    err_d   = beat_err;
                    baddr_d = addr_q[BUF_ADDR_WIDTH+1:2];
                    wdata_d = WDATA;
                    wstrb_d = WSTRB;
                    cnt_d   = cnt_q + 8'd1;
                    unique case (burst_q)
                        2'b01:   addr_d = addr_inc;
                        2'b10:   addr_d = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
                        default: addr_d = addr_q;
                    endcase
                    if (last_beat) begin
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bresp_d  = beat_err ? 2'b10 : 2'b00;
                        bid_d    = id_q;
                        state_d  = StResp;
                    end
                end
            end
            StResp: begin
                if (BREADY && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = StIdle;
                end
            end
            default: begin
                awready_d = 1'b0;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
                busy_d    = 1'b0;
                state_d   = StIdle;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q   <= StIdle;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            bid_q     <= '0;
            we_q      <= 1'b0;
            baddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            bid_q     <= bid_d;
            we_q      <= we_d;
            baddr_q   <= baddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            busy_q    <= busy_d;
        end
    end

    assign AWREADY   = awready_q;
    assign WREADY    = wready_q;
    assign BVALID    = bvalid_q;
    assign BRESP     = bresp_q;
    assign BID       = bid_q;
    assign buf_we    = we_q;
    assign buf_addr  = baddr_q;
    assign buf_wdata = wdata_q;
    assign buf_wstrb = wstrb_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_axi4_operand_loader.sv
// Directed self-checking bench for axi4_operand_loader; inputs driven and outputs sampled
// on the falling edge so every handshake lands on the following rising edge.
module tb_axi4_operand_loader;

    localparam int AW = 32;
    localparam int IW = 1;
    localparam int BW = 8;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [IW-1:0] AWID;
    logic [AW-1:0] AWADDR;
    logic [7:0]    AWLEN;
    logic [2:0]    AWSIZE;
    logic [1:0]    AWBURST;
    logic          AWVALID;
    logic          AWREADY;
    logic [31:0]   WDATA;
    logic [3:0]    WSTRB;
    logic          WLAST;
    logic          WVALID;
    logic          WREADY;
    logic [IW-1:0] BID;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;
    logic          buf_we;
    logic [BW-1:0] buf_addr;
    logic [31:0]   buf_wdata;
    logic [3:0]    buf_wstrb;
    logic          busy;

    axi4_operand_loader #(
        .ADDR_WIDTH    (AW),
        .ID_WIDTH      (IW),
        .BUF_ADDR_WIDTH(BW)
    ) dut (
        .ACLK     (ACLK),
        .ARESET   (ARESET),
        .AWID     (AWID),
        .AWADDR   (AWADDR),
        .AWLEN    (AWLEN),
        .AWSIZE   (AWSIZE),
        .AWBURST  (AWBURST),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WLAST    (WLAST),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BID      (BID),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .buf_we   (buf_we),
        .buf_addr (buf_addr),
        .buf_wdata(buf_wdata),
        .buf_wstrb(buf_wstrb),
        .busy     (busy)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    logic [BW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    logic [3:0]    wr_strb[$];
    int            wr_cyc[$];
    int            hs_cyc[$];

    always @(negedge ACLK) begin
        if (buf_we === 1'b1) begin
            wr_addr.push_back(buf_addr);
            wr_data.push_back(buf_wdata);
            wr_strb.push_back(buf_wstrb);
            wr_cyc.push_back(cyc);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] beat_data(input int i);
        if (i == 0) return 32'hFFFF_FFFF;
        if (i == 15) return 32'h00AB_CDEF;
        return 32'h1000_0000 + 32'(i) * 32'h0001_0101;
    endfunction

    task automatic clear_log();
        wr_addr.delete();
        wr_data.delete();
        wr_strb.delete();
        wr_cyc.delete();
    endtask

    task automatic do_aw(input logic [IW-1:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
        int t = 0;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst;
        AWVALID = 1'b1;
        while (AWREADY !== 1'b1 && t < 20) begin
            @(negedge ACLK);
            t++;
        end
        check_eq("aw_accept", 32'(AWREADY), 32'd1);
        @(negedge ACLK);
        AWVALID = 1'b0;
        check_eq("wready_after_aw", 32'(WREADY), 32'd1);
        check_eq("busy_in_burst", 32'(busy), 32'd1);
    endtask

    task automatic do_w(input int n, input int wlast_at, input bit gap, input logic [3:0] strb);
        int   i = 0;
        int   t = 0;
        logic fire;
        hs_cyc.delete();
        while (i < n && t < 200) begin
            WVALID = gap ? (t % 2 == 0) : 1'b1;
            WDATA  = beat_data(i);
            WSTRB  = strb;
            WLAST  = (i == wlast_at);
            fire   = WVALID && (WREADY === 1'b1);
            @(negedge ACLK);
            t++;
            if (fire) begin
                hs_cyc.push_back(cyc);
                i++;
            end
        end
        WVALID = 1'b0;
        WLAST  = 1'b0;
        check_eq("beats_accepted", 32'(i), 32'(n));
    endtask

    task automatic do_b(input logic [1:0] exp_resp, input logic [IW-1:0] exp_id, input int hold);
        int t = 0;
        while (BVALID !== 1'b1 && t < 20) begin
            @(negedge ACLK);
            t++;
        end
        check_eq("bvalid", 32'(BVALID), 32'd1);
        check_eq("bresp", 32'(BRESP), 32'(exp_resp));
        check_eq("bid", 32'(BID), 32'(exp_id));
        for (int k = 0; k < hold; k++) begin
            @(negedge ACLK);
            check_eq("bvalid_hold", 32'(BVALID), 32'd1);
            check_eq("bresp_hold", 32'(BRESP), 32'(exp_resp));
            check_eq("awready_hold", 32'(AWREADY), 32'd0);
        end
        BREADY = 1'b1;
        @(negedge ACLK);
        BREADY = 1'b0;
        check_eq("bvalid_clear", 32'(BVALID), 32'd0);
        check_eq("awready_after_b", 32'(AWREADY), 32'd1);
        check_eq("busy_after_b", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] exp_resp6;
        int         exp_n6;

        ARESET = 1'b1; AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0;
        AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        @(negedge ACLK);
        @(negedge ACLK);
        check_eq("rst_awready", 32'(AWREADY), 32'd0);
        check_eq("rst_wready", 32'(WREADY), 32'd0);
        check_eq("rst_bvalid", 32'(BVALID), 32'd0);
        check_eq("rst_bresp", 32'(BRESP), 32'd0);
        check_eq("rst_bid", 32'(BID), 32'd0);
        check_eq("rst_buf_we", 32'(buf_we), 32'd0);
        check_eq("rst_buf_addr", 32'(buf_addr), 32'd0);
        check_eq("rst_buf_wdata", buf_wdata, 32'd0);
        check_eq("rst_buf_wstrb", 32'(buf_wstrb), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        ARESET = 1'b0;
        @(negedge ACLK);
        check_eq("awready_after_rst", 32'(AWREADY), 32'd1);

        // INCR 16 beats from 0, continuous
        clear_log();
        do_aw(1'b1, 32'h0, 8'd15, 3'b010, 2'b01);
        do_w(16, 15, 1'b0, 4'hF);
        check_eq("incr_bvalid_next", 32'(BVALID), 32'd1);
        do_b(2'b00, 1'b1, 0);
        check_eq("incr_nwrites", 32'(wr_addr.size()), 32'd16);
        for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
            check_eq("incr_addr", 32'(wr_addr[i]), 32'(i));
            check_eq("incr_data", wr_data[i], beat_data(i));
            check_eq("incr_strb", 32'(wr_strb[i]), 32'hF);
            check_eq("incr_back2back", 32'(wr_cyc[i]), 32'(wr_cyc[0] + i));
        end

        // WRAP 16 beats from 0x20
        clear_log();
        do_aw(1'b0, 32'h20, 8'd15, 3'b010, 2'b10);
        do_w(16, 15, 1'b0, 4'hF);
        do_b(2'b00, 1'b0, 0);
        check_eq("wrap_nwrites", 32'(wr_addr.size()), 32'd16);
        for (int i = 0; i < 16 && i < wr_addr.size(); i++) begin
            check_eq("wrap_addr", 32'(wr_addr[i]), (i < 8) ? 32'(8 + i) : 32'(i - 8));
            check_eq("wrap_data", wr_data[i], beat_data(i));
        end

        // Illegal AWSIZE, then illegal WRAP length
        clear_log();
        do_aw(1'b0, 32'h40, 8'd3, 3'b001, 2'b01);
        do_w(4, 3, 1'b0, 4'hF);
        do_b(2'b10, 1'b0, 0);
        check_eq("badsize_nwrites", 32'(wr_addr.size()), 32'd0);
        clear_log();
        do_aw(1'b1, 32'h0, 8'd2, 3'b010, 2'b10);
        do_w(3, 2, 1'b0, 4'hF);
        do_b(2'b10, 1'b1, 0);
        check_eq("badwrap_nwrites", 32'(wr_addr.size()), 32'd0);

        // INCR 4 beats with gaps, BREADY withheld
        clear_log();
        do_aw(1'b0, 32'h100, 8'd3, 3'b010, 2'b01);
        do_w(4, 3, 1'b1, 4'h5);
        do_b(2'b00, 1'b0, 5);
        check_eq("gap_nwrites", 32'(wr_addr.size()), 32'd4);
        for (int i = 0; i < 4 && i < wr_addr.size() && i < hs_cyc.size(); i++) begin
            check_eq("gap_we_timing", 32'(wr_cyc[i]), 32'(hs_cyc[i]));
            check_eq("gap_addr", 32'(wr_addr[i]), 32'(64 + i));
            check_eq("gap_strb", 32'(wr_strb[i]), 32'h5);
        end

        // Reset mid-burst after 5 of 16 beats
        clear_log();
        do_aw(1'b1, 32'h0, 8'd15, 3'b010, 2'b01);
        do_w(5, 15, 1'b0, 4'hF);
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        check_eq("midrst_buf_we", 32'(buf_we), 32'd0);
        check_eq("midrst_bvalid", 32'(BVALID), 32'd0);
        check_eq("midrst_wready", 32'(WREADY), 32'd0);
        check_eq("midrst_awready", 32'(AWREADY), 32'd0);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge ACLK);
            check_eq("midrst_no_bvalid", 32'(BVALID), 32'd0);
        end
        check_eq("midrst_nwrites", 32'(wr_addr.size()), 32'd5);
        clear_log();
        do_aw(1'b0, 32'h4, 8'd0, 3'b010, 2'b01);
        do_w(1, 0, 1'b0, 4'hF);
        do_b(2'b00, 1'b0, 0);
        check_eq("postrst_nwrites", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() > 0) check_eq("postrst_addr", 32'(wr_addr[0]), 32'd1);

        // Early WLAST on beat 2 of 4
`ifdef LOADER_WLAST_CHECK_EN
        exp_n6 = 2; exp_resp6 = 2'b10;
`else
        exp_n6 = 4; exp_resp6 = 2'b00;
`endif
        clear_log();
        do_aw(1'b1, 32'h200, 8'd3, 3'b010, 2'b01);
        do_w(4, 2, 1'b0, 4'hF);
        do_b(exp_resp6, 1'b1, 0);
        check_eq("wlast_nwrites", 32'(wr_addr.size()), 32'(exp_n6));
        for (int i = 0; i < exp_n6 && i < wr_addr.size(); i++) begin
            check_eq("wlast_addr", 32'(wr_addr[i]), 32'(128 + i));
            check_eq("wlast_data", wr_data[i], beat_data(i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
